// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants, the receive-side lock FSM state type
// and a saturating counter helper. The generator side imports this package too.
package vga_timing_pkg;

    // Horizontal timing in pixel clocks, counted from the HS leading edge.
    localparam int H_SYNC      = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 784;
    localparam int H_TOTAL     = 800;

    // Vertical timing in lines, counted from the VS leading edge.
    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 515;
    localparam int V_TOTAL     = 525;

    // Position counters are 11 bits. All ones marks "no sync seen for too long".
    localparam int                CNT_W   = 11;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : CNT_W'(v + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registered sync level plus leading-edge detect.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : sample strobe; the level register only moves when en=1
//   din        : raw sync input
//   lead       : combinational, 1 when this sample enters the sync level
//                while the stored previous sample was outside it
module sync_edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic lead
);

    logic lvl_q;
    logic lvl_d;

    always_comb begin
        lvl_d = en ? din : lvl_q;
    end

    // Reset to the inactive level so a sync already asserted at release
    // is seen as a leading edge on the first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= ~POL;
        else        lvl_q <= lvl_d;
    end

    assign lead = en && (din == POL) && (lvl_q != POL);

endmodule

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor. Recovers pixel coordinates from HS/VS
// leading edges, checks line/frame lengths, runs a HUNT/CHECK/LOCKED lock FSM
// and forwards validated active-area pixels.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pix_ce                : one-clk pixel strobe; all state moves only on it
//   hs, vs, r_in/g_in/b_in: sampled stream
//   pix_valid             : pulse, locked and sample inside the active window
//   pix_x, pix_y          : active-area coordinate of that sample
//   pix_r, pix_g, pix_b   : colour of that sample
//   frame_start           : pulse on each VS leading edge
//   locked                : timing validated
//   err_line, err_frame   : pulses on line/frame length mismatch
module vga_timing_monitor #(
    parameter int   H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int   H_ACT_START = vga_timing_pkg::H_ACT_START,
    parameter int   H_ACT_END   = vga_timing_pkg::H_ACT_END,
    parameter int   V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int   V_ACT_START = vga_timing_pkg::V_ACT_START,
    parameter int   V_ACT_END   = vga_timing_pkg::V_ACT_END,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r_in,
    input  logic [3:0]  g_in,
    input  logic [3:0]  b_in,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [3:0]  pix_r,
    output logic [3:0]  pix_g,
    output logic [3:0]  pix_b,
    output logic        frame_start,
    output logic        locked,
    output logic        err_line,
    output logic        err_frame
);

    import vga_timing_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_AS   = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] H_AE   = CNT_W'(H_ACT_END);
    localparam logic [CNT_W-1:0] V_AS   = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] V_AE   = CNT_W'(V_ACT_END);
    localparam logic [7:0]       LOCK_N = 8'(LOCK_FRAMES);

    // ---------------------------------------------------------------- edges
    logic hs_lead, vs_lead;

    sync_edge_det #(.POL(SYNC_POL)) u_hs_det (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_ce),
        .din   (hs),
        .lead  (hs_lead)
    );

    sync_edge_det #(.POL(SYNC_POL)) u_vs_det (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_ce),
        .din   (vs),
        .lead  (vs_lead)
    );

    // ---------------------------------------------------------------- state
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    lock_state_e      state_q, state_d;
    logic [7:0]       clean_q, clean_d;
    logic             dirty_q, dirty_d;      // current frame already had an error
    logic             h_chk_q, h_chk_d;      // a previous HS edge exists to measure from
    logic             v_chk_q, v_chk_d;

    logic             pix_valid_q, pix_valid_d;
    logic [10:0]      pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [3:0]       pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
    logic             frame_start_q, frame_start_d;
    logic             locked_q, locked_d;
    logic             err_line_q, err_line_d;
    logic             err_frame_q, err_frame_d;

    // Next-sample values, meaningful only when pix_ce=1.
    logic [CNT_W-1:0] hcnt_nx, vcnt_nx;
    lock_state_e      state_nx;
    logic [7:0]       clean_nx;
    logic             dirty_nx;
    logic             err_l, err_f, err_any, sat, in_win;

    always_comb begin
        hcnt_nx = hs_lead ? '0 : sat_inc(hcnt_q);

        // VS wins over the line increment when both edges land together.
        if (vs_lead)      vcnt_nx = '0;
        else if (hs_lead) vcnt_nx = sat_inc(vcnt_q);
        else              vcnt_nx = vcnt_q;

        // hs_lead/vs_lead are already qualified by pix_ce.
        err_l   = hs_lead && h_chk_q && (hcnt_q != H_LAST);
        err_f   = vs_lead && v_chk_q && (vcnt_q != V_LAST);
        err_any = err_l || err_f;
        sat     = (hcnt_nx == CNT_MAX) || (vcnt_nx == CNT_MAX);
        in_win  = (hcnt_nx >= H_AS) && (hcnt_nx < H_AE) &&
                  (vcnt_nx >= V_AS) && (vcnt_nx < V_AE);

        state_nx = state_q;
        clean_nx = clean_q;
        dirty_nx = dirty_q;

        unique case (state_q)
            HUNT: begin
                if (vs_lead) begin
                    state_nx = CHECK;
                    clean_nx = '0;
                    dirty_nx = 1'b0;
                end
            end
            CHECK: begin
                if (vs_lead) begin
                    // A frame only counts if nothing went wrong anywhere in
                    // it, including its closing edge.
                    dirty_nx = 1'b0;
                    if (err_any || dirty_q) begin
                        clean_nx = '0;
                    end else if (clean_q + 8'd1 >= LOCK_N) begin
                        state_nx = LOCKED;
                        clean_nx = '0;
                    end else begin
                        clean_nx = clean_q + 8'd1;
                    end
                end else if (err_any) begin
                    clean_nx = '0;
                    dirty_nx = 1'b1;
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_nx = CHECK;
                    clean_nx = '0;
                    // An error on a VS edge closes the bad frame; the new
                    // frame starts clean.
                    dirty_nx = !vs_lead;
                end
            end
            default: begin
                state_nx = HUNT;
                clean_nx = '0;
                dirty_nx = 1'b0;
            end
        endcase

        // Lost sync for too long: counters are meaningless, start over.
        if (sat) begin
            state_nx = HUNT;
            clean_nx = '0;
            dirty_nx = 1'b0;
        end
    end

    always_comb begin
        hcnt_d  = pix_ce ? hcnt_nx  : hcnt_q;
        vcnt_d  = pix_ce ? vcnt_nx  : vcnt_q;
        state_d = pix_ce ? state_nx : state_q;
        clean_d = pix_ce ? clean_nx : clean_q;
        dirty_d = pix_ce ? dirty_nx : dirty_q;

        // Length checks need a measured reference edge; HUNT discards it.
        h_chk_d = h_chk_q;
        v_chk_d = v_chk_q;
        if (pix_ce) begin
            h_chk_d = (state_nx != HUNT) && (h_chk_q || hs_lead);
            v_chk_d = (state_nx != HUNT) && (v_chk_q || vs_lead);
        end

        pix_valid_d   = pix_ce && (state_nx == LOCKED) && in_win;
        frame_start_d = vs_lead;
        err_line_d    = err_l;
        err_frame_d   = err_f;
        locked_d      = pix_ce ? (state_nx == LOCKED) : locked_q;

        pix_x_d = pix_valid_d ? (hcnt_nx - H_AS) : pix_x_q;
        pix_y_d = pix_valid_d ? (vcnt_nx - V_AS) : pix_y_q;
        pix_r_d = pix_valid_d ? r_in : pix_r_q;
        pix_g_d = pix_valid_d ? g_in : pix_g_q;
        pix_b_d = pix_valid_d ? b_in : pix_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= CNT_MAX;
            vcnt_q        <= CNT_MAX;
            state_q       <= HUNT;
            clean_q       <= '0;
            dirty_q       <= 1'b0;
            h_chk_q       <= 1'b0;
            v_chk_q       <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            state_q       <= state_d;
            clean_q       <= clean_d;
            dirty_q       <= dirty_d;
            h_chk_q       <= h_chk_d;
            v_chk_q       <= v_chk_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            err_line_q    <= err_line_d;
            err_frame_q   <= err_frame_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err_line    = err_line_q;
    assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor on a shrunken raster (20x10 total,
// 12x6 active) so that many frames fit in a short run. The driver plays a
// generator and pushes the expected output tuple for every pixel it sends;
// the monitor pops one tuple per pixel strobe and compares.
module tb_vga_timing_monitor;

    localparam int   HT   = 20;
    localparam int   HSW  = 3;
    localparam int   HAS  = 4;
    localparam int   HAE  = 16;
    localparam int   VT   = 10;
    localparam int   VSW  = 2;
    localparam int   VAS  = 2;
    localparam int   VAE  = 8;
    localparam logic POL  = 1'b1;
    localparam int   NACT = (HAE - HAS) * (VAE - VAS);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic        hs = ~POL, vs = ~POL;
    logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
    logic        pix_valid, frame_start, locked, err_line, err_frame;
    logic [10:0] pix_x, pix_y;
    logic [3:0]  pix_r, pix_g, pix_b;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT_END(VAE),
        .SYNC_POL(POL), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .hs(hs), .vs(vs),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .locked(locked),
        .err_line(err_line), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v, fs, el, ef, lk;
        logic [10:0] x, y;
        logic [3:0]  r, g, b;
        int          gx, gy;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   nvalid = 0;
    bit   exp_lk = 1'b0;
    bit   ce_d = 1'b0;

    always @(posedge clk) ce_d <= pix_ce;

    // ------------------------------------------------------------- monitor
    exp_t m;
    always @(negedge clk) begin
        if (pix_valid) nvalid++;
        if (ce_d) begin
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL scoreboard_underflow: output strobe with no expected entry");
            end else begin
                m = q.pop_front();
                if ({pix_valid, frame_start, err_line, err_frame, locked} !=
                        {m.v, m.fs, m.el, m.ef, m.lk} ||
                    (m.v && {pix_x, pix_y, pix_r, pix_g, pix_b} !=
                        {m.x, m.y, m.r, m.g, m.b})) begin
                    nerr++;
                    if (nerr <= 30)
                        $display("FAIL pixel(%0d,%0d): got v=%b fs=%b el=%b ef=%b lk=%b x=%0d y=%0d rgb=%h%h%h, want v=%b fs=%b el=%b ef=%b lk=%b x=%0d y=%0d rgb=%h%h%h",
                                 m.gx, m.gy, pix_valid, frame_start, err_line, err_frame, locked,
                                 pix_x, pix_y, pix_r, pix_g, pix_b,
                                 m.v, m.fs, m.el, m.ef, m.lk, m.x, m.y, m.r, m.g, m.b);
                end
            end
        end else if (rst_n && (pix_valid || frame_start || err_line || err_frame)) begin
            nerr++;
            if (nerr <= 30)
                $display("FAIL idle_pulse: got v=%b fs=%b el=%b ef=%b outside a strobe, want all 0",
                         pix_valid, frame_start, err_line, err_frame);
        end
    end

    // ------------------------------------------------------------- driver
    task automatic pix(input logic h, input logic v, input exp_t e);
        @(negedge clk);
        hs = h; vs = v; r_in = e.r; g_in = e.g; b_in = e.b;
        pix_ce = 1'b1;
        q.push_back(e);
        @(negedge clk);
        pix_ce = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        nvec++;
        if ({pix_valid, frame_start, err_line, err_frame, locked,
             pix_x, pix_y, pix_r, pix_g, pix_b} != '0) begin
            nerr++;
            $display("FAIL %s: got v=%b fs=%b el=%b ef=%b lk=%b x=%0d y=%0d, want all 0",
                     name, pix_valid, frame_start, err_line, err_frame, locked, pix_x, pix_y);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_all_zero("midframe_reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_lk = 1'b0;
    endtask

    // One generated frame. lk0: expected locked from the VS edge sample on;
    // short_ln: line sent with HT-1 pixels (-1 none); ef: err_frame expected
    // at the VS edge; rst_ln: line on which reset is pulsed after pixel 8.
    task automatic send_frame(input int nl, input int short_ln, input bit lk0,
                              input bit ef, input int rst_ln);
        exp_t e;
        int   len;
        for (int y = 0; y < nl; y++) begin
            len = (y == short_ln) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) begin
                if (x == 0 && y == 0) exp_lk = lk0;
                e.el = (short_ln >= 0) && (x == 0) && (y == short_ln + 1);
                if (e.el) exp_lk = 1'b0;
                e.fs = (x == 0) && (y == 0);
                e.ef = ef && (x == 0) && (y == 0);
                e.lk = exp_lk;
                e.v  = exp_lk && x >= HAS && x < HAE && y >= VAS && y < VAE;
                e.x  = 11'(x - HAS);
                e.y  = 11'(y - VAS);
                e.r  = 4'(x);
                e.g  = 4'(y);
                e.b  = 4'(x + 3 * y);
                e.gx = x;
                e.gy = y;
                pix((x < HSW) ? POL : ~POL, (y < VSW) ? POL : ~POL, e);
                if (y == rst_ln && x == 8) do_reset();
            end
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    int   snap;
    exp_t s;
    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        check_count("reset_hcnt", int'(dut.hcnt_q), 2047);
        check_count("reset_vcnt", int'(dut.vcnt_q), 2047);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal: lock at the third VS edge.
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 1, 0, -1);
        snap = nvalid;
        send_frame(VT, -1, 1, 0, -1);
        check_count("valid_per_frame_nominal", nvalid - snap, NACT);

        // Short line while locked, then two clean frames to relock.
        send_frame(VT, 3, 1, 0, -1);
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 1, 0, -1);

        // Short frame: err_frame and unlock at the next VS edge.
        send_frame(VT - 1, -1, 1, 0, -1);
        send_frame(VT, -1, 0, 1, -1);
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 1, 0, -1);

        // HS stuck inactive: hcnt saturates after 2047-(HT-1) samples.
        for (int i = 1; i <= 3000; i++) begin
            s = '{v: 1'b0, fs: 1'b0, el: 1'b0, ef: 1'b0,
                  lk: ((HT - 1 + i) < 2047), x: '0, y: '0,
                  r: 4'(i), g: 4'(i), b: 4'(i), gx: i, gy: -1};
            pix(~POL, ~POL, s);
        end
        exp_lk = 1'b0;
        check_count("stuck_hcnt_saturated", int'(dut.hcnt_q), 2047);

        // Recovery from HUNT; first HS edge after HUNT is not checked.
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 0, 0, -1);
        snap = nvalid;
        send_frame(VT, -1, 1, 0, -1);
        check_count("valid_per_frame_relock", nvalid - snap, NACT);

        // Reset mid active line, then three VS edges to lock again.
        send_frame(VT, -1, 1, 0, 4);
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 0, 0, -1);
        snap = nvalid;
        send_frame(VT, -1, 1, 0, -1);
        check_count("valid_per_frame_after_reset", nvalid - snap, NACT);

        repeat (4) @(negedge clk);
        check_count("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
